// File: rtl/ddr_arb_pkg.sv
// Shared constants, FSM state type and sizing helper for the DDR2 request arbiter.
package ddr_arb_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WDATA = 2'd2
   } arb_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ddr_tag_fifo.sv
// Small synchronous FIFO holding the issuing channel of each outstanding read burst.
module ddr_tag_fifo
   import ddr_arb_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ddr_req_arbiter.sv
// N-channel arbiter onto the DDR2 af/wdf FIFO pair; write bursts stay atomic, reads return in order.
//   state | meaning
//   IDLE  | pick a winner among eligible command requests
//   GRANT | forward owner's command to af, wait for af space
//   WDATA | forward owner's BURST_BEATS write beats to wdf
module ddr_req_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int NUM_CH      = 6,
   parameter int ADDR_W      = 31,
   parameter int DATA_W      = 128,
   parameter int MASK_W      = 16,
   parameter int BURST_BEATS = 2,
   parameter int TAG_DEPTH   = 8,
   parameter int ARB_MODE    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*3-1:0]      ch_af_cmd_din,
   input  logic [NUM_CH*ADDR_W-1:0] ch_af_addr_din,
   input  logic [NUM_CH-1:0]        ch_af_wr_en,
   output logic [NUM_CH-1:0]        ch_af_full,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdf_din,
   input  logic [NUM_CH*MASK_W-1:0] ch_wdf_mask_din,
   input  logic [NUM_CH-1:0]        ch_wdf_wr_en,
   output logic [NUM_CH-1:0]        ch_wdf_full,
   input  logic [NUM_CH-1:0]        ch_rdf_rd_en,
   output logic [NUM_CH-1:0]        ch_rdf_valid,
   output logic [2:0]               af_cmd_din,
   output logic [ADDR_W-1:0]        af_addr_din,
   output logic                     af_wr_en,
   input  logic                     af_full,
   output logic [DATA_W-1:0]        wdf_din,
   output logic [MASK_W-1:0]        wdf_mask_din,
   output logic                     wdf_wr_en,
   input  logic                     wdf_full,
   input  logic                     rdf_valid,
   output logic                     rdf_rd_en,
   output logic                     orphan_err
);

   localparam int TAG_W  = clog2(NUM_CH);
   localparam int BEAT_W = clog2(BURST_BEATS) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

   logic [2:0]        cmd_arr   [NUM_CH];
   logic [ADDR_W-1:0] addr_arr  [NUM_CH];
   logic [DATA_W-1:0] wdata_arr [NUM_CH];
   logic [MASK_W-1:0] mask_arr  [NUM_CH];

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic [TAG_W-1:0]  owner;
   logic [TAG_W-1:0]  rr_ptr;
   logic [TAG_W-1:0]  winner;
   logic              found;
   logic [NUM_CH-1:0] elig;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] rbeat;
   logic [2:0]        owner_cmd;

   logic              tag_push;
   logic              tag_pop;
   logic              tag_full;
   logic              tag_empty;
   logic [TAG_W-1:0]  tag_head;

   // Unpack the flat per-channel buses; reads are held off while no tag slot is free.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign cmd_arr[g]      = ch_af_cmd_din[3*g +: 3];
      assign addr_arr[g]     = ch_af_addr_din[ADDR_W*g +: ADDR_W];
      assign wdata_arr[g]    = ch_wdf_din[DATA_W*g +: DATA_W];
      assign mask_arr[g]     = ch_wdf_mask_din[MASK_W*g +: MASK_W];
      assign elig[g]         = ch_af_wr_en[g] & ~((cmd_arr[g] == CMD_READ) & tag_full);
      assign ch_rdf_valid[g] = rdf_valid & ~tag_empty & (tag_head == TAG_W'(g));
   end

   // Both loops run from the lowest-preference candidate upward so the last hit wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      if (ARB_MODE == 0) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[TAG_W'(i)]) begin
               winner = TAG_W'(i);
               found  = 1'b1;
            end
         end
      end else begin
         for (int k = NUM_CH; k >= 1; k--) begin
            if (elig[TAG_W'((int'(rr_ptr) + k) % NUM_CH)]) begin
               winner = TAG_W'((int'(rr_ptr) + k) % NUM_CH);
               found  = 1'b1;
            end
         end
      end
   end

   assign owner_cmd    = cmd_arr[owner];
   assign af_cmd_din   = owner_cmd;
   assign af_addr_din  = addr_arr[owner];
   assign wdf_din      = wdata_arr[owner];
   assign wdf_mask_din = mask_arr[owner];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (found) state_nxt = GRANT;
         GRANT: if (af_wr_en) state_nxt = (owner_cmd == CMD_WRITE) ? WDATA : IDLE;
         WDATA: if (wdf_wr_en && (beat == LAST_BEAT)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ch_af_full  = '1;
      ch_wdf_full = '1;
      af_wr_en    = 1'b0;
      wdf_wr_en   = 1'b0;
      case (state)
         GRANT: begin
            ch_af_full[owner] = af_full;
            af_wr_en          = ch_af_wr_en[owner] & ~af_full;
         end
         WDATA: begin
            ch_wdf_full[owner] = wdf_full;
            wdf_wr_en          = ch_wdf_wr_en[owner] & ~wdf_full;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner  <= '0;
         rr_ptr <= TAG_W'(NUM_CH - 1);
         beat   <= '0;
      end else begin
         if ((state == IDLE) && found) owner <= winner;
         if (af_wr_en) begin
            rr_ptr <= owner;
            beat   <= '0;
         end else if (wdf_wr_en) begin
            beat <= beat + BEAT_W'(1);
         end
      end
   end

   assign rdf_rd_en = |(ch_rdf_valid & ch_rdf_rd_en);
   assign tag_push  = af_wr_en & (owner_cmd == CMD_READ);
   assign tag_pop   = rdf_rd_en & (rbeat == LAST_BEAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbeat      <= '0;
         orphan_err <= 1'b0;
      end else begin
         if (rdf_rd_en) rbeat <= (rbeat == LAST_BEAT) ? '0 : rbeat + BEAT_W'(1);
         if (rdf_valid && tag_empty) orphan_err <= 1'b1;
      end
   end

   ddr_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tag_push),
      .pop   (tag_pop),
      .din   (owner),
      .dout  (tag_head),
      .full  (tag_full),
      .empty (tag_empty)
   );

endmodule

// File: doc/ddr_req_arbiter.md
Name: ddr_req_arbiter

Overview:
- Parametrised N-channel DDR2 request arbiter. It replaces the fixed icache/dcache/pixel/filler/line/cmd request controller in the memory subsystem.
- Multiplexes per-client address/command and write-data FIFO requests onto the single af/wdf clock-crossing FIFO pair on the cpu clock.
- Keeps whole write bursts atomic per client.
- Routes returning read beats to the issuing client through an in-order tag FIFO.
- Arbitration is selectable: fixed-priority or round-robin.

Parameters:
NUM_CH, 6, number of client channels (2..8); channel 0 = highest fixed priority
ADDR_W, 31, DDR2 address width
DATA_W, 128, write/read data beat width
MASK_W, 16, write mask width (DATA_W/8)
BURST_BEATS, 2, data beats per write command and per read return
TAG_DEPTH, 8, outstanding reads (power of 2)
ARB_MODE, 1, 0 = fixed priority, 1 = round-robin

Ports:
clk  in  1  cpu clock
rst_n  in  1  asynchronous active-low reset
ch_af_cmd_din  in  NUM_CH*3  per-channel command, slice i = [3i+2:3i]
ch_af_addr_din  in  NUM_CH*ADDR_W  per-channel address
ch_af_wr_en  in  NUM_CH  command request; held until accepted
ch_af_full  out  NUM_CH  per-channel backpressure
ch_wdf_din  in  NUM_CH*DATA_W  per-channel write data
ch_wdf_mask_din  in  NUM_CH*MASK_W  per-channel write mask
ch_wdf_wr_en  in  NUM_CH  write beat valid
ch_wdf_full  out  NUM_CH  write-data backpressure
ch_rdf_rd_en  in  NUM_CH  client pops read beat
ch_rdf_valid  out  NUM_CH  read beat available to channel
af_cmd_din  out  3  to address FIFO
af_addr_din  out  ADDR_W  to address FIFO
af_wr_en  out  1  address FIFO push
af_full  in  1  address FIFO full
wdf_din  out  DATA_W  to write FIFO
wdf_mask_din  out  MASK_W  to write FIFO
wdf_wr_en  out  1  write FIFO push
wdf_full  in  1  write FIFO full
rdf_valid  in  1  read FIFO has data (rdf_dout is fanned out externally)
rdf_rd_en  out  1  read FIFO pop
orphan_err  out  1  sticky: rdf_valid seen with empty tag FIFO

Behaviour:
- Handshake: a client asserts ch_af_wr_en with stable cmd/addr and holds it. Acceptance is the cycle where ch_af_wr_en[i]=1 and ch_af_full[i]=0. The same rule applies to wdf.
- Commands: 3'b000 = write, 3'b001 = read (constants in package). Any other code is treated as a read-less write-less command: forwarded, no data phase, no tag.
- Reset values: ch_af_full and ch_wdf_full all 1; ch_rdf_valid 0; af_wr_en, wdf_wr_en, rdf_rd_en 0; orphan_err 0; state IDLE; tag FIFO empty; rr_ptr = NUM_CH-1 (channel 0 first); beat counters 0.
- Reset is asynchronous mid-burst. A partially sent write burst is abandoned; the downstream FIFOs are reset by the same system reset.
- FSM IDLE:
  - Eligible set = ch_af_wr_en, with read requests masked while the tag FIFO is full.
  - Fixed mode: lowest eligible index wins. RR mode: first eligible index after rr_ptr, wrapping.
  - Winner is registered into owner and the FSM moves to GRANT. With no eligible request, stay in IDLE.
  - All ch_af_full = 1.
- FSM GRANT:
  - ch_af_full[owner] = af_full; all others 1.
  - af_* driven combinationally from the owner slice; af_wr_en = ch_af_wr_en[owner] & ~af_full.
  - On acceptance, rr_ptr <= owner.
  - Read accepted: push owner into the tag FIFO, go to IDLE.
  - Write accepted: go to WDATA with beat = 0.
  - Other command accepted: go to IDLE.
  - Stays in GRANT while af_full.
- FSM WDATA:
  - ch_wdf_full[owner] = wdf_full; all others 1.
  - wdf_* muxed from owner; each accepted beat increments beat.
  - Beat BURST_BEATS-1 accepted: go to IDLE.
  - Beats from non-owners are never forwarded.
  - ch_wdf_full is 1 for every channel outside WDATA.
- Latency: request first seen in IDLE, granted and forwardable on the next cycle. Minimum 2 cycles per read command; minimum 2 + BURST_BEATS cycles per write.
- Read return:
  - head = tag FIFO head.
  - ch_rdf_valid[i] = rdf_valid & ~tag_empty & (head==i).
  - rdf_rd_en = |(ch_rdf_valid & ch_rdf_rd_en).
  - Each pop increments rbeat. On the BURST_BEATS-th pop, pop the tag and clear rbeat.
- Simultaneous tag push (GRANT read accept) and pop in the same cycle: both occur and the count is unchanged. A push into a full FIFO cannot happen because full masks eligibility.
- rdf_valid with tag FIFO empty: rdf_rd_en stays 0 and orphan_err is set until reset.
- Tag width = clog2(NUM_CH). Beat counters are clog2(BURST_BEATS)+1 bits. All address/data widths pass through unmodified.

Decomposition:
- Package ddr_arb_pkg: CMD_WRITE/CMD_READ constants, FSM state enum {IDLE, GRANT, WDATA}, clog2 function.
- One sub-module, ddr_tag_fifo: synchronous FIFO with async active-low reset, parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty.

Test Plan:
- Fixed mode, ch0 and ch3 both request read addr 0x100/0x200 in the same cycle -> af gets ch0 first, ch3 two cycles later; two rdf bursts route ch_rdf_valid to bit 0 then bit 3.
- RR mode, ch1, ch2, ch4 continuously requesting reads -> grant order 1,2,4,1,2,4; no starvation over 30 grants.
- ch2 write addr 0x40 with beats 0xA..A/0xB..B, ch5 write requesting concurrently -> wdf receives A, B contiguously from ch2 before any ch5 beat; ch5 ch_wdf_full stays 1 meanwhile.
- TAG_DEPTH=8 reads outstanding with no return -> 9th read held (ch_af_full=1) while a write from another channel is still granted; after one burst is returned, the 9th read is accepted.
- af_full held 1 for 5 cycles during GRANT -> af_wr_en stays 0, owner unchanged; command issued on the cycle af_full drops.
- rst_n pulsed low during WDATA after beat 0; and separately rdf_valid=1 with an empty tag FIFO -> all outputs return to reset values; orphan_err=1, rdf_rd_en=0.
